// File: rtl/sram_arbiter_pkg.sv
// Shared types and widths for the SRAM arbiter: FSM states, bus widths and
// the latched access descriptor.
package sram_arbiter_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  // Access captured at the grant edge and held for its whole duration
  typedef struct packed {
    logic              gnt_mem;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  // Wait-counter load value for a given strobe length
  function automatic logic [CNT_W-1:0] wait_load(input int unsigned cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester and SRAM-side signal bundle for sram_arbiter; slave is the
// arbiter's view, master is the view of the pipeline/SRAM surroundings.
interface sram_arbiter_if;
  import sram_arbiter_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_data;
  logic              if_ack;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  logic              stall_req;

  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic              sram_data_oe;
  logic [DATA_W-1:0] sram_rdata;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;

  modport slave (
    input  if_req, if_addr,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  sram_rdata,
    output if_data, if_ack,
    output mem_rdata, mem_ack,
    output stall_req,
    output sram_addr, sram_wdata, sram_data_oe,
    output sram_ce_n, sram_oe_n, sram_we_n
  );

  modport master (
    output if_req, if_addr,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output sram_rdata,
    input  if_data, if_ack,
    input  mem_rdata, mem_ack,
    input  stall_req,
    input  sram_addr, sram_wdata, sram_data_oe,
    input  sram_ce_n, sram_oe_n, sram_we_n
  );

endinterface

// File: rtl/sram_arbiter.sv
// Arbitrates instruction-fetch and data accesses onto one asynchronous SRAM,
// data side first, with registered strobes and a programmable strobe length.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic          clk,
  input logic          rst,
  sram_arbiter_if.slave bus
);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  acc_t              r_acc;
  logic [DATA_W-1:0] r_if_data;
  logic [DATA_W-1:0] r_mem_rdata;
  logic              r_if_ack;
  logic              r_mem_ack;
  logic              r_ce_n;
  logic              r_oe_n;
  logic              r_we_n;
  logic              r_data_oe;

  acc_t              w_req_sel;
  logic              w_any_req;
  logic              w_write;
  logic              w_cnt_done;

  // Grant selection: the data side always wins a simultaneous request
  always_comb begin
    w_req_sel         = '0;
    w_req_sel.gnt_mem = bus.mem_req;
    w_req_sel.addr    = bus.mem_req ? bus.mem_addr : bus.if_addr;
    w_req_sel.wdata   = bus.mem_wdata;
  end

  assign w_any_req  = bus.if_req | bus.mem_req;
  assign w_write    = bus.mem_req & bus.mem_we;
  assign w_cnt_done = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_if_data   <= '0;
      r_mem_rdata <= '0;
      r_if_ack    <= 1'b0;
      r_mem_ack   <= 1'b0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_data_oe   <= 1'b0;
    end else begin
      r_if_ack  <= 1'b0;
      r_mem_ack <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_acc.gnt_mem <= w_req_sel.gnt_mem;
            r_acc.addr    <= w_req_sel.addr;
            r_ce_n        <= 1'b0;
            if (w_write) begin
              r_acc.wdata <= w_req_sel.wdata;
              r_data_oe   <= 1'b1;
              r_state     <= ST_WR_SETUP;
            end else begin
              r_oe_n  <= 1'b0;
              r_cnt   <= wait_load(WAIT_CYCLES);
              r_state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (w_cnt_done) begin
            if (r_acc.gnt_mem) begin
              r_mem_rdata <= bus.sram_rdata;
              r_mem_ack   <= 1'b1;
            end else begin
              r_if_data <= bus.sram_rdata;
              r_if_ack  <= 1'b1;
            end
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_WR_SETUP: begin
          r_we_n  <= 1'b0;
          r_cnt   <= wait_load(WAIT_CYCLES);
          r_state <= ST_WR_PULSE;
        end
        ST_WR_PULSE: begin
          if (w_cnt_done) begin
            r_we_n  <= 1'b1;
            r_state <= ST_WR_HOLD;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_WR_HOLD: begin
          r_ce_n    <= 1'b1;
          r_data_oe <= 1'b0;
          r_mem_ack <= 1'b1;
          r_state   <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_ce_n    <= 1'b1;
          r_oe_n    <= 1'b1;
          r_we_n    <= 1'b1;
          r_data_oe <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.if_data      = r_if_data;
  assign bus.if_ack       = r_if_ack;
  assign bus.mem_rdata    = r_mem_rdata;
  assign bus.mem_ack      = r_mem_ack;
  assign bus.sram_addr    = r_acc.addr;
  assign bus.sram_wdata   = r_acc.wdata;
  assign bus.sram_data_oe = r_data_oe;
  assign bus.sram_ce_n    = r_ce_n;
  assign bus.sram_oe_n    = r_oe_n;
  assign bus.sram_we_n    = r_we_n;

  // Stall must react in the same cycle a request appears or an ack retires it
  assign bus.stall_req = (bus.if_req & ~r_if_ack) | (bus.mem_req & ~r_mem_ack);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: strobe/stall checks inline, ack timing and
// data checked by a scoreboard monitor against hand-computed expectations.
module tb_sram_arbiter;

  typedef struct {
    int          dut;
    bit          is_mem;
    logic [15:0] data;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rdata;
  int unsigned cyc = 0;
  int unsigned base;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_arbiter_if ifc1 ();
  sram_arbiter_if ifc3 ();

  assign ifc1.sram_rdata = rdata;
  assign ifc3.sram_rdata = rdata;

  sram_arbiter #(.WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(ifc1.slave));
  sram_arbiter #(.WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(ifc3.slave));

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle count %0d)", name, act, exp, cyc);
    end
  endfunction

  // {ce_n, oe_n, we_n, data_oe}
  function automatic void chk_s1(input string name, input logic [3:0] exp);
    chk(name, 32'({ifc1.sram_ce_n, ifc1.sram_oe_n, ifc1.sram_we_n, ifc1.sram_data_oe}), 32'(exp));
  endfunction

  function automatic void chk_s3(input string name, input logic [3:0] exp);
    chk(name, 32'({ifc3.sram_ce_n, ifc3.sram_oe_n, ifc3.sram_we_n, ifc3.sram_data_oe}), 32'(exp));
  endfunction

  task automatic push(input int d, input bit m, input logic [15:0] data, input int unsigned c);
    exp_t e;
    e.dut = d; e.is_mem = m; e.data = data; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic mon(input int d, input logic ia, input logic ma,
                     input logic [15:0] id, input logic [15:0] md);
    exp_t e;
    if (ia === 1'b1 || ma === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk($sformatf("unexpected_ack_dut%0d", d), 32'({ia, ma}), 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("ack_dut", 32'(d), 32'(e.dut));
        chk("ack_kind", 32'({ia, ma}), e.is_mem ? 32'h1 : 32'h2);
        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
        chk("ack_data", 32'(e.is_mem ? md : id), 32'(e.data));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, ifc1.if_ack, ifc1.mem_ack, ifc1.if_data, ifc1.mem_rdata);
    mon(1, ifc3.if_ack, ifc3.mem_ack, ifc3.if_data, ifc3.mem_rdata);
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    ifc1.if_req = 0; ifc1.if_addr = '0; ifc1.mem_req = 0; ifc1.mem_we = 0;
    ifc1.mem_addr = '0; ifc1.mem_wdata = '0;
    ifc3.if_req = 0; ifc3.if_addr = '0; ifc3.mem_req = 0; ifc3.mem_we = 0;
    ifc3.mem_addr = '0; ifc3.mem_wdata = '0;
    rdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk_s1("rst_strobes1", 4'b1110);
    chk_s3("rst_strobes3", 4'b1110);
    chk("rst_addr", 32'(ifc1.sram_addr), 32'h0);
    chk("rst_wdata", 32'(ifc1.sram_wdata), 32'h0);
    chk("rst_acks", 32'({ifc1.if_ack, ifc1.mem_ack}), 32'h0);
    chk("rst_if_data", 32'(ifc1.if_data), 32'h0);

    // Fetch read, WAIT_CYCLES=1
    base = cyc;
    ifc1.if_req = 1; ifc1.if_addr = 16'h0010; rdata = 16'h4E01;
    push(0, 1'b0, 16'h4E01, base + 2);
    #1;
    chk("t1_stall_c0", 32'(ifc1.stall_req), 32'h1);
    chk_s1("t1_strobes_c0", 4'b1110);
    step();
    chk_s1("t1_strobes_c1", 4'b0010);
    chk("t1_addr_c1", 32'(ifc1.sram_addr), 32'h0010);
    chk("t1_stall_c1", 32'(ifc1.stall_req), 32'h1);
    step();
    chk_s1("t1_strobes_c2", 4'b1110);
    chk("t1_stall_c2", 32'(ifc1.stall_req), 32'h0);
    ifc1.if_req = 0;
    step();
    chk_s1("t1_strobes_c3", 4'b1110);

    // Data write
    base = cyc;
    ifc1.mem_req = 1; ifc1.mem_we = 1; ifc1.mem_addr = 16'hBF00; ifc1.mem_wdata = 16'h1234;
    push(0, 1'b1, 16'h0000, base + 4);
    #1;
    chk("t2_stall_c0", 32'(ifc1.stall_req), 32'h1);
    step();
    chk_s1("t2_strobes_c1", 4'b0111);
    chk("t2_addr_c1", 32'(ifc1.sram_addr), 32'hBF00);
    step();
    chk_s1("t2_strobes_c2", 4'b0101);
    chk("t2_wdata_c2", 32'(ifc1.sram_wdata), 32'h1234);
    step();
    chk_s1("t2_strobes_c3", 4'b0111);
    chk("t2_addr_c3", 32'(ifc1.sram_addr), 32'hBF00);
    step();
    chk_s1("t2_strobes_c4", 4'b1110);
    chk("t2_stall_c4", 32'(ifc1.stall_req), 32'h0);
    ifc1.mem_req = 0; ifc1.mem_we = 0;
    step();

    // Simultaneous requests: data read first, fetch afterwards
    base = cyc;
    rdata = 16'hA5A5;
    ifc1.mem_req = 1; ifc1.mem_we = 0; ifc1.mem_addr = 16'h8000;
    ifc1.if_req = 1; ifc1.if_addr = 16'h0020;
    push(0, 1'b1, 16'hA5A5, base + 2);
    push(0, 1'b0, 16'h0F0F, base + 5);
    step();
    chk("t3_addr_c1", 32'(ifc1.sram_addr), 32'h8000);
    chk_s1("t3_strobes_c1", 4'b0010);
    step();
    chk("t3_stall_c2", 32'(ifc1.stall_req), 32'h1);
    chk_s1("t3_strobes_c2", 4'b1110);
    ifc1.mem_req = 0;
    step();
    chk("t3_stall_c3", 32'(ifc1.stall_req), 32'h1);
    chk_s1("t3_strobes_c3", 4'b1110);
    rdata = 16'h0F0F;
    step();
    chk("t3_addr_c4", 32'(ifc1.sram_addr), 32'h0020);
    chk_s1("t3_strobes_c4", 4'b0010);
    step();
    chk("t3_mem_rdata_hold", 32'(ifc1.mem_rdata), 32'hA5A5);
    ifc1.if_req = 0;
    step();

    // Reset during the write pulse aborts the access with no ack
    ifc1.mem_req = 1; ifc1.mem_we = 1; ifc1.mem_addr = 16'h1111; ifc1.mem_wdata = 16'h2222;
    step();
    step();
    chk_s1("t4_strobes_pulse", 4'b0101);
    rst = 1'b1;
    step();
    chk_s1("t4_strobes_after_rst", 4'b1110);
    chk("t4_addr_cleared", 32'(ifc1.sram_addr), 32'h0);
    chk("t4_wdata_cleared", 32'(ifc1.sram_wdata), 32'h0);
    chk("t4_mem_rdata_cleared", 32'(ifc1.mem_rdata), 32'h0);
    chk("t4_if_data_cleared", 32'(ifc1.if_data), 32'h0);
    rst = 1'b0;
    ifc1.mem_req = 0; ifc1.mem_we = 0;
    step();
    step();
    chk_s1("t4_strobes_idle", 4'b1110);

    // Fetch request dropped mid-access still completes
    base = cyc;
    ifc1.if_req = 1; ifc1.if_addr = 16'h0033; rdata = 16'h1357;
    push(0, 1'b0, 16'h1357, base + 2);
    step();
    chk_s1("t5_strobes_c1", 4'b0010);
    ifc1.if_req = 0;
    step();
    chk_s1("t5_strobes_c2", 4'b1110);
    step();
    chk_s1("t5_strobes_c3", 4'b1110);
    step();
    chk_s1("t5_strobes_c4", 4'b1110);

    // WAIT_CYCLES=3 fetch read
    base = cyc;
    ifc3.if_req = 1; ifc3.if_addr = 16'h0044; rdata = 16'h2468;
    push(1, 1'b0, 16'h2468, base + 4);
    for (int c = 1; c <= 3; c++) begin
      step();
      chk_s3($sformatf("t6_strobes_c%0d", c), 4'b0010);
    end
    step();
    chk_s3("t6_strobes_c4", 4'b1110);
    ifc3.if_req = 0;
    step();

    // WAIT_CYCLES=3 data write
    base = cyc;
    ifc3.mem_req = 1; ifc3.mem_we = 1; ifc3.mem_addr = 16'h0ABC; ifc3.mem_wdata = 16'hBEEF;
    push(1, 1'b1, 16'h0000, base + 6);
    step();
    chk_s3("t7_strobes_c1", 4'b0111);
    for (int c = 2; c <= 4; c++) begin
      step();
      chk_s3($sformatf("t7_strobes_c%0d", c), 4'b0101);
    end
    chk("t7_wdata", 32'(ifc3.sram_wdata), 32'hBEEF);
    step();
    chk_s3("t7_strobes_c5", 4'b0111);
    step();
    chk_s3("t7_strobes_c6", 4'b1110);
    ifc3.mem_req = 0; ifc3.mem_we = 0;
    step();
    step();

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
